page_table: RTL
===============

PAGE_TABLE -- requirements
Module: page_table

Interface
REQ-001 SHALL have parameter VPN_W, default 6, virtual page number width (64 entries).
REQ-002 SHALL have parameter PPN_W, default 2, physical page number width (4 frames).
REQ-003 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports req_valid (in, 1, TLB miss or writeback request) and req_ready (out, 1, request accepted when both high).
REQ-005 SHALL have ports req_write (in, 1, 1 = writeback of status bits, 0 = PTE read) and req_vpn (in, VPN_W, target page).
REQ-006 SHALL have port wb_dirty_ref (in, 2, dirty/ref bits to store on writeback).
REQ-007 SHALL have ports resp_valid (out, 1), resp_ready (in, 1), resp_pte (out, 32, bit31 valid, bit30 dirty, bit29 ref, [PPN_W-1:0] PPN, others 0).
REQ-008 SHALL have port pg_fault (out, 1, qualified by resp_valid, requested PTE was invalid).
REQ-009 SHALL have ports cfg_we (in, 1), cfg_vpn (in, VPN_W), cfg_pte (in, 32) for direct table preload.

Function
REQ-010 SHALL hold 2**VPN_W 32-bit PTEs in registers.
REQ-011 SHALL implement FSM IDLE -> LOOKUP -> (ALLOC) -> RESP -> IDLE.
REQ-012 SHALL assert req_ready only in IDLE with cfg_we low; request captured on that edge.
REQ-013 LOOKUP: read request SHALL latch PTE[req_vpn]; writeback SHALL set PTE[req_vpn][30:29] = wb_dirty_ref and latch updated PTE.
REQ-014 Writeback to an invalid PTE SHALL leave the table unchanged and respond with pg_fault=1.
REQ-015 Read of valid PTE SHALL give resp_valid on the 2nd rising edge after acceptance, pg_fault=0.
REQ-016 Read of invalid PTE SHALL go to ALLOC if PT_FAULT_ALLOC_EN, else RESP with pg_fault=1.
REQ-017 resp_valid, resp_pte, pg_fault SHALL stay stable in RESP until resp_ready high on a rising edge; same edge returns to IDLE.
REQ-018 cfg_we SHALL write PTE[cfg_vpn] = cfg_pte on any cycle; write to the VPN latched in an in-flight request before LOOKUP SHALL be visible to that lookup.
REQ-019 All outputs SHALL be registered; resp_pte SHALL be 0 outside RESP.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, req_ready=0 while low, resp_valid=0, pg_fault=0, resp_pte=0.
REQ-021 Reset SHALL clear every PTE, allocation pointer and frame-owner table; in-flight request is discarded with no response.

Configuration
REQ-022 Macro PT_FAULT_ALLOC_EN defined: ALLOC state (1 cycle) picks frame at round-robin pointer alloc_ptr, clears valid bit of the PTE recorded as that frame's previous owner, writes PTE[req_vpn] = valid, dirty 0, ref 1, PPN=alloc_ptr, records owner, increments alloc_ptr mod 2**PPN_W, responds with new PTE and pg_fault=1 (latency 3 edges).
REQ-023 Macro undefined: no ALLOC state, no owner table, no pointer; faults respond per REQ-016.
REQ-024 Owner table SHALL also update on cfg_we writes with valid=1 only when PT_FAULT_ALLOC_EN defined.

Structure
REQ-025 Shared package SHALL hold PTE bit-position constants (VALID=31, DIRTY=30, REF=29) and the FSM state enum, also used by the TLB.
REQ-026 Single module; no sub-module.

Verification
REQ-027 cfg write vpn 0x05 -> 0x8000_0002, read vpn 0x05 -> resp_pte 0x8000_0002, pg_fault 0, resp_valid on 2nd edge.
REQ-028 Writeback vpn 0x05 dirty_ref 2'b11 -> following read returns 0xE000_0002.
REQ-029 Read unmapped vpn 0x3F, macro off -> resp_pte 0x0000_0000, pg_fault 1.
REQ-030 Macro on, five faults on vpns 0x10..0x14 -> PPNs 0,1,2,3,0; then read 0x10 -> pg_fault 1 (evicted).
REQ-031 resp_ready held low 5 cycles -> resp_pte stable, req_ready 0 throughout.
REQ-032 rst_n pulsed low in LOOKUP -> no response; read of vpn 0x05 afterwards -> pg_fault 1.

Source files
------------

// File: rtl/page_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : page_table_pkg
// Brief    : PTE bit positions and walker FSM states shared by page table and TLB
// Revision : 1.0
// ============================================================================
package page_table_pkg;

    localparam int c_pte_valid = 31;
    localparam int c_pte_dirty = 30;
    localparam int c_pte_ref   = 29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ALLOC  = 2'd2,
        ST_RESP   = 2'd3
    } pt_state_e;

endpackage
`default_nettype wire

// File: rtl/page_table.sv
`default_nettype none
// ============================================================================
// Module   : page_table
// Brief    : Register-based page table with PTE read, status writeback and
//            optional round-robin fault allocation (macro PT_FAULT_ALLOC_EN)
// Revision : 1.0
// ============================================================================
module page_table
    import page_table_pkg::*;
#(
    parameter int VPN_W = 6,
    parameter int PPN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [VPN_W-1:0] req_vpn,
    input  logic [1:0]       wb_dirty_ref,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_pte,
    output logic             pg_fault,
    input  logic             cfg_we,
    input  logic [VPN_W-1:0] cfg_vpn,
    input  logic [31:0]      cfg_pte
);

    localparam int          c_entries  = 2**VPN_W;
    localparam logic [31:0] c_pte_mask = (32'h1 << c_pte_valid) | (32'h1 << c_pte_dirty) |
                                         (32'h1 << c_pte_ref)   | ((32'h1 << PPN_W) - 32'h1);

    pt_state_e        r_state;
    logic [31:0]      r_pte [c_entries];
    logic [VPN_W-1:0] r_vpn;
    logic             r_write;
    logic [1:0]       r_wb_dr;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_pg_fault;
    logic [31:0]      r_resp_pte;

    logic             w_accept;
    logic [31:0]      w_lookup_pte;
    logic [31:0]      w_wb_pte;

`ifdef PT_FAULT_ALLOC_EN
    localparam int    c_frames = 2**PPN_W;
    logic [PPN_W-1:0] r_alloc_ptr;
    logic [VPN_W-1:0] r_owner [c_frames];
    logic [c_frames-1:0] r_owner_vld;
    logic [31:0]      w_alloc_pte;

    always_comb begin
        w_alloc_pte              = '0;
        w_alloc_pte[c_pte_valid] = 1'b1;
        w_alloc_pte[c_pte_ref]   = 1'b1;
        w_alloc_pte[PPN_W-1:0]   = r_alloc_ptr;
    end
`endif

    // A table preload occupies the cycle, so new requests are held off while it lands
    assign req_ready  = r_req_ready & ~cfg_we;
    assign resp_valid = r_resp_valid;
    assign resp_pte   = r_resp_pte;
    assign pg_fault   = r_pg_fault;
    assign w_accept   = (r_state == ST_IDLE) && req_valid && req_ready;

    // A preload to the in-flight VPN landing on the lookup edge is forwarded
    always_comb begin
        w_lookup_pte = r_pte[r_vpn];
        if (cfg_we && (cfg_vpn == r_vpn)) begin
            w_lookup_pte = cfg_pte & c_pte_mask;
        end
        w_wb_pte                        = w_lookup_pte;
        w_wb_pte[c_pte_dirty:c_pte_ref] = r_wb_dr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vpn        <= '0;
            r_write      <= 1'b0;
            r_wb_dr      <= 2'b00;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_pg_fault   <= 1'b0;
            r_resp_pte   <= '0;
            for (int i = 0; i < c_entries; i++) begin
                r_pte[i] <= '0;
            end
`ifdef PT_FAULT_ALLOC_EN
            r_alloc_ptr <= '0;
            r_owner_vld <= '0;
            for (int i = 0; i < c_frames; i++) begin
                r_owner[i] <= '0;
            end
`endif
        end else begin
            // Preload first; same-edge FSM updates to the same entry take priority
            if (cfg_we) begin
                r_pte[cfg_vpn] <= cfg_pte & c_pte_mask;
`ifdef PT_FAULT_ALLOC_EN
                if (cfg_pte[c_pte_valid]) begin
                    r_owner[cfg_pte[PPN_W-1:0]]     <= cfg_vpn;
                    r_owner_vld[cfg_pte[PPN_W-1:0]] <= 1'b1;
                end
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_vpn       <= req_vpn;
                        r_write     <= req_write;
                        r_wb_dr     <= wb_dirty_ref;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (w_lookup_pte[c_pte_valid]) begin
                        if (r_write) begin
                            r_pte[r_vpn] <= w_wb_pte;
                            r_resp_pte   <= w_wb_pte;
                        end else begin
                            r_resp_pte   <= w_lookup_pte;
                        end
                        r_pg_fault   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
`ifdef PT_FAULT_ALLOC_EN
                    end else if (!r_write) begin
                        r_state      <= ST_ALLOC;
`endif
                    end else begin
                        r_resp_pte   <= w_lookup_pte;
                        r_pg_fault   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
`ifdef PT_FAULT_ALLOC_EN
                ST_ALLOC: begin
                    // Evict the previous owner before installing, so a self-owner ends valid
                    if (r_owner_vld[r_alloc_ptr]) begin
                        r_pte[r_owner[r_alloc_ptr]][c_pte_valid] <= 1'b0;
                    end
                    r_pte[r_vpn]             <= w_alloc_pte;
                    r_owner[r_alloc_ptr]     <= r_vpn;
                    r_owner_vld[r_alloc_ptr] <= 1'b1;
                    r_alloc_ptr              <= r_alloc_ptr + 1'b1;
                    r_resp_pte               <= w_alloc_pte;
                    r_pg_fault               <= 1'b1;
                    r_resp_valid             <= 1'b1;
                    r_state                  <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_pg_fault   <= 1'b0;
                        r_resp_pte   <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
